// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_adder_ctrl_pkg;

    localparam int STATE_W   = 2;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Single-bit combinational full adder; the only arithmetic cell in the serial datapath.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first, one bit per cycle.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sr, b_sr, s_sr;
    logic               carry;
    logic [CNT_W-1:0]   idx;
    logic               last_bit;
    logic               fa_sum, fa_carry;

    assign last_bit = (idx == CNT_W'(WIDTH - 1));

    fa_bit u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)    state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    // NOTE: the shift registers are ordinary flops, not a RAM, so they take the async reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= sub ? ~b_in : b_in;
                        carry <= sub ? 1'b1 : cin;
                        s_sr  <= '0;
                        idx   <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
                    carry <= fa_carry;
                    // Reload on the last bit so idx never passes WIDTH-1 for any WIDTH.
                    idx   <= last_bit ? '0 : idx + CNT_W'(1);
                end
                ST_DONE: begin
                    sum_out <= s_sr;
                    cout    <= carry;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table plus busy, reset and back-to-back sequences.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, sub, cin;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, cout;
    logic [W-1:0] sum_out;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub     (sub),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c);
        a_in  = a;
        b_in  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycles are counted in negedges after the accepting edge; returns at the done negedge.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 1;
        busy_cnt = 0;
        while (!done && cycles <= 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int cyc, bcnt, dones;
        logic hold_ok;
        logic [W-1:0] seen_sum;
        logic         seen_cout;

        vecs[0] = '{a: 8'h3C, b: 8'h45, sub: 1'b0, cin: 1'b0, sum: 8'h81, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, sub: 1'b0, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h10, b: 8'h01, sub: 1'b1, cin: 1'b1, sum: 8'h0F, cout: 1'b1};
        vecs[4] = '{a: 8'h01, b: 8'h02, sub: 1'b1, cin: 1'b1, sum: 8'hFF, cout: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b0, cin: 1'b1, sum: 8'h01, cout: 1'b0};
        vecs[6] = '{a: 8'h80, b: 8'h80, sub: 1'b1, cin: 1'b0, sum: 8'h00, cout: 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",  32'(busy),    32'd0);
        check("reset_done",  32'(done),    32'd0);
        check("reset_sum",   32'(sum_out), 32'd0);
        check("reset_cout",  32'(cout),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_done(cyc, bcnt);
            check($sformatf("vec%0d_sum", i),    32'(sum_out), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i),   32'(cout),    32'(vecs[i].cout));
            check($sformatf("vec%0d_cycles", i), cyc,          32'd10);
            check($sformatf("vec%0d_busy", i),   bcnt,         32'd9);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // Start while busy must be ignored; operands change mid-operation.
        launch(8'h05, 8'h03, 1'b0, 1'b0);
        dones = 0; seen_sum = '0; seen_cout = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            if (c == 3) begin start = 1'b1; a_in = 8'hAA; b_in = 8'h55; end
            if (c == 4) begin start = 1'b0; a_in = 8'hFF; b_in = 8'hFF; end
            if (done) begin dones++; seen_sum = sum_out; seen_cout = cout; end
            @(negedge clk);
        end
        check("busyprot_sum",   32'(seen_sum),  32'h08);
        check("busyprot_cout",  32'(seen_cout), 32'd0);
        check("busyprot_dones", dones,          32'd1);
        check("busyprot_idle",  32'(busy),      32'd0);

        // Leave a nonzero result with cout=1 so the reset clearing is observable.
        launch(8'hFF, 8'hFF, 1'b0, 1'b1);
        wait_done(cyc, bcnt);
        check("pre_reset_cout", 32'(cout), 32'd1);
        @(negedge clk);

        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy),    32'd0);
        check("midrst_done", 32'(done),    32'd0);
        check("midrst_sum",  32'(sum_out), 32'd0);
        check("midrst_cout", 32'(cout),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        check("midrst_no_done", dones, 32'd0);
        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(cyc, bcnt);
        check("after_rst_sum",  32'(sum_out), 32'h80);
        check("after_rst_cout", 32'(cout),    32'd0);
        @(negedge clk);

        // Back-to-back: second start issued in the done cycle; old result must hold.
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(cyc, bcnt);
        check("b2b_first_sum", 32'(sum_out), 32'h46);
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        hold_ok = 1'b1;
        cyc = 1;
        while (!done && cyc <= 20) begin
            if (sum_out !== 8'h46) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("b2b_hold",       32'(hold_ok), 32'd1);
        check("b2b_done_seen",  32'(done),    32'd1);
        check("b2b_cycles",     cyc,          32'd10);
        check("b2b_second_sum", 32'(sum_out), 32'h02);
        check("b2b_cout",       32'(cout),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder/subtractor built around one single-bit full-adder cell.
- On each cycle, the block feeds one operand bit pair plus the stored carry into the cell. It captures the sum bit into a shift register and registers the carry for the next bit.
- The block sits directly upstream of the full-adder cell and consumes its sum/carry outputs. It serves as the area-minimal arithmetic stage for the lab datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (must be ≥ 2).
- CNT_W, $clog2(WIDTH), bit-index counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A−B (B inverted, carry-in forced to 1).
- a_in  input  WIDTH  operand A; captured on accepted start.
- b_in  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle completion pulse.
- sum_out  output  WIDTH  result; held until the next completion.
- cout  output  1  final carry. In sub mode, 1 means no borrow.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0; done=0; sum_out=0; cout=0.
  - Internal shift registers, carry flop and counter are all cleared.
  - Any in-flight operation is discarded.
- FSM states:
  - IDLE: start=1 → load A_sr=a_in, B_sr=(sub ? ~b_in : b_in), carry=(sub ? 1 : cin), S_sr=0, idx=0; go to SHIFT. With start=0, stay in IDLE.
  - SHIFT, one bit per cycle, LSB first:
    - The cell inputs are (A_sr[0], B_sr[0], carry).
    - A_sr and B_sr shift right by 1.
    - S_sr shifts right, and the cell sum enters at the MSB.
    - carry takes the cell carry.
    - idx increments.
    - When idx==WIDTH−1 in this cycle, go to DONE.
  - DONE: sum_out←S_sr; cout←carry; done=1 for this cycle only; next state is IDLE.
- Latency:
  - Let start be accepted at edge E0.
  - SHIFT occupies edges E0+1 … E0+WIDTH.
  - done=1 and sum_out/cout are valid in the cycle after edge E0+WIDTH+1.
  - Total is WIDTH+2 cycles from start to return to IDLE.
- Throughput: a new start is accepted no earlier than the cycle after DONE (back-to-back spacing of WIDTH+2 cycles).
- busy=1 in SHIFT and DONE.
- start while busy is ignored. It is not queued and causes no error.
- a_in, b_in, sub and cin may change freely after the accepted start; they have no effect until the next accepted start.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - cout is the true carry out of bit WIDTH−1.
  - No overflow flag is produced.
- sum_out and cout change only in DONE or on reset. The previous result stays visible while a new operation is in progress.
- Counter wrap: idx never exceeds WIDTH−1; it is reloaded to 0 on each accepted start.

Decomposition:
- Shared package:
  - FSM state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - The 2-bit state width.
  - The default WIDTH.
- Sub-module:
  - One instance of fa_bit, a purely combinational 1-bit full adder (inputs a, b, c; outputs sum, carry).
  - The controller (FSM, counter, shift registers, carry flop, result registers) stays in this module.

Test Plan:
- Add, WIDTH=8: a_in=0x3C, b_in=0x45, cin=0, sub=0, start pulse → done after 10 cycles; sum_out=0x81, cout=0; busy high for exactly 9 cycles.
- Carry ripple: 0xFF+0x01, cin=0 → sum_out=0x00, cout=1. Also 0xFF+0xFF, cin=1 → sum_out=0xFF, cout=1.
- Subtract:
  - 0x10−0x01 → sum_out=0x0F, cout=1.
  - 0x01−0x02 → sum_out=0xFF, cout=0.
  - cin driven to 1 during both cases has no effect.
- Busy protection:
  - Start 0x05+0x03.
  - Pulse start with 0xAA+0x55 at SHIFT cycle 3, and change a_in/b_in mid-operation.
  - Expected: result is 0x08, cout=0; exactly one done pulse; the second request is not executed.
- Reset mid-operation:
  - Assert rst asynchronously (between edges) during SHIFT cycle 4 of 0x7F+0x01.
  - Expected: busy/done/sum_out/cout go to 0 immediately; no done follows.
  - A fresh 0x7F+0x01 then yields 0x80, cout=0.
- Result hold and back-to-back:
  - After 0x12+0x34 (sum_out=0x46), start 0x01+0x01 in the cycle after done.
  - Expected: sum_out stays 0x46 until the second done, then becomes 0x02.
